// File: rtl/uart_cmd_pkg.sv
// Shared types and byte codes for the UART command responder.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_WB_REQ,
    ST_RESP
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

endpackage

// File: rtl/uart_cmd_responder_if.sv
// Wishbone master bus bundle driven by the UART command responder.
interface uart_cmd_responder_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// UART byte-command to Wishbone bridge: 'W' adr4 dat4 / 'R' adr4, replies ACK/NAK or read data.
// Optional Wishbone watchdog enabled by defining UART_CMD_WBTO_EN.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned WB_TMO = 255
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic [15:0] cfg_gap_tmo,
  output logic        busy,
  uart_cmd_responder_if.master wbm
);

  state_t      r_state;
  logic        r_we;
  logic        r_cyc;
  logic        r_stb;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat_o;
  logic [1:0]  r_byte_cnt;
  logic [15:0] r_gap_cnt;
  logic [31:0] r_resp;
  logic        r_resp_multi;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data;
  logic        w_wdog_exp;
  logic        w_wb_fail;
  logic        w_last_tx;

`ifdef UART_CMD_WBTO_EN
  logic [31:0] r_wdog;

  always_ff @(posedge mclk) begin
    if (reset || r_state != ST_WB_REQ) r_wdog <= '0;
    else                               r_wdog <= r_wdog + 32'd1;
  end

  assign w_wdog_exp = (r_state == ST_WB_REQ) && (r_wdog == 32'(WB_TMO - 1));
`else
  assign w_wdog_exp = 1'b0;
`endif

  // err (or watchdog expiry) overrides a simultaneous ack
  assign w_wb_fail = wbm.wbm_err_i | w_wdog_exp;
  assign w_last_tx = !r_resp_multi || (r_byte_cnt == 2'd3);

  always_ff @(posedge mclk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_sel        <= '0;
      r_adr        <= '0;
      r_dat_o      <= '0;
      r_byte_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_resp       <= '0;
      r_resp_multi <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_byte_cnt <= '0;
          r_gap_cnt  <= '0;
          if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
            r_we    <= (rx_data == CMD_WRITE);
            r_state <= ST_ADDR;
          end
        end

        ST_ADDR, ST_WDATA: begin
          if (rx_valid) begin
            r_gap_cnt  <= '0;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_state == ST_ADDR) r_adr   <= {r_adr[23:0], rx_data};
            else                    r_dat_o <= {r_dat_o[23:0], rx_data};
            if (r_byte_cnt == 2'd3) begin
              if (r_state == ST_ADDR && r_we) begin
                r_state <= ST_WDATA;
              end else begin
                r_state <= ST_WB_REQ;
                r_cyc   <= 1'b1;
                r_stb   <= 1'b1;
                r_sel   <= '1;
              end
            end
          end else if (cfg_gap_tmo != '0) begin
            // counter never passes cfg_gap_tmo, so the increment cannot wrap
            if (r_gap_cnt >= cfg_gap_tmo) begin
              r_state    <= ST_IDLE;
              r_byte_cnt <= '0;
              r_gap_cnt  <= '0;
            end else begin
              r_gap_cnt <= r_gap_cnt + 16'd1;
            end
          end
        end

        ST_WB_REQ: begin
          if (wbm.wbm_ack_i || w_wb_fail) begin
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_state    <= ST_RESP;
            r_byte_cnt <= '0;
            r_tx_valid <= 1'b1;
            if (w_wb_fail) begin
              r_resp       <= {RSP_NAK, 24'h0};
              r_tx_data    <= RSP_NAK;
              r_resp_multi <= 1'b0;
            end else if (r_we) begin
              r_resp       <= {RSP_ACK, 24'h0};
              r_tx_data    <= RSP_ACK;
              r_resp_multi <= 1'b0;
            end else begin
              r_resp       <= wbm.wbm_dat_i;
              r_tx_data    <= wbm.wbm_dat_i[31:24];
              r_resp_multi <= 1'b1;
            end
          end
        end

        ST_RESP: begin
          if (r_tx_valid && tx_ready) begin
            if (w_last_tx) begin
              r_tx_valid <= 1'b0;
              r_state    <= ST_IDLE;
              r_byte_cnt <= '0;
            end else begin
              r_resp     <= {r_resp[23:0], 8'h00};
              r_tx_data  <= r_resp[23:16];
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_valid      = r_tx_valid;
  assign tx_data       = r_tx_data;
  assign busy          = (r_state != ST_IDLE);
  assign wbm.wbm_cyc_o = r_cyc;
  assign wbm.wbm_stb_o = r_stb;
  assign wbm.wbm_we_o  = r_we;
  assign wbm.wbm_adr_o = r_adr;
  assign wbm.wbm_dat_o = r_dat_o;
  assign wbm.wbm_sel_o = r_sel;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder (watchdog case runs when UART_CMD_WBTO_EN is defined).
module tb_uart_cmd_responder;

  typedef logic [7:0] byte_q_t [$];
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_exp_t;

  localparam int M_ACK    = 0;
  localparam int M_ERR    = 1;
  localparam int M_BOTH   = 2;
  localparam int M_SILENT = 3;
`ifdef UART_CMD_WBTO_EN
  localparam bit WBTO = 1'b1;
`else
  localparam bit WBTO = 1'b0;
`endif

  logic        mclk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [15:0] cfg_gap_tmo;
  logic        busy;

  uart_cmd_responder_if wb ();

  uart_cmd_responder #(.WB_TMO(255)) dut (
    .mclk        (mclk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .cfg_gap_tmo (cfg_gap_tmo),
    .busy        (busy),
    .wbm         (wb)
  );

  int          checks = 0;
  int          errors = 0;
  wb_exp_t     exp_wb[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];
  logic [31:0] last_adr, last_dat;
  logic        last_we;
  int          slv_mode = M_ACK;
  int          slv_lat  = 0;
  int          slv_cnt  = 0;
  logic [31:0] slv_rdata = '0;
  logic        prev_cyc = 1'b0, prev_v = 1'b0, prev_r = 1'b0;

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  initial begin
    #600000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Model: what a complete command must produce on the bus and on tx.
  task automatic model_cmd(input byte_q_t b, input int mode, input logic [31:0] rdata);
    wb_exp_t e;
    logic    ok;
    ok = (mode == M_ACK);
    if (b.size() == 9 && b[0] == 8'h57) begin
      e.we = 1'b1; e.adr = {b[1], b[2], b[3], b[4]}; e.dat = {b[5], b[6], b[7], b[8]};
      exp_wb.push_back(e);
      if (ok) exp_tx.push_back(8'h06);
      else if (mode != M_SILENT || WBTO) exp_tx.push_back(8'h15);
    end else if (b.size() == 5 && b[0] == 8'h52) begin
      e.we = 1'b0; e.adr = {b[1], b[2], b[3], b[4]}; e.dat = '0;
      exp_wb.push_back(e);
      if (ok) for (int i = 3; i >= 0; i--) exp_tx.push_back(rdata[i*8 +: 8]);
      else if (mode != M_SILENT || WBTO) exp_tx.push_back(8'h15);
    end
  endtask

  task automatic send_bytes(input byte_q_t b, input int gap);
    foreach (b[i]) begin
      tick();
      rx_valid = 1'b1;
      rx_data  = b[i];
      tick();
      rx_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic run_cmd(input byte_q_t b, input int mode, input logic [31:0] rdata, input int gap);
    slv_mode  = mode;
    slv_rdata = rdata;
    tx_log.delete();
    model_cmd(b, mode, rdata);
    send_bytes(b, gap);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!busy && exp_tx.size() == 0 && exp_wb.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL %s timeout busy=%0d pending_tx=%0d pending_wb=%0d", name, busy, exp_tx.size(), exp_wb.size());
  endtask

  // Wishbone slave: responds after slv_lat wait cycles according to slv_mode.
  always begin
    @(posedge mclk);
    #1;
    wb.wbm_ack_i = 1'b0;
    wb.wbm_err_i = 1'b0;
    wb.wbm_dat_i = slv_rdata;
    if (wb.wbm_cyc_o && wb.wbm_stb_o && slv_mode != M_SILENT) begin
      if (slv_cnt >= slv_lat) begin
        wb.wbm_ack_i = (slv_mode == M_ACK || slv_mode == M_BOTH);
        wb.wbm_err_i = (slv_mode == M_ERR || slv_mode == M_BOTH);
        slv_cnt = 0;
      end else begin
        slv_cnt++;
      end
    end else begin
      slv_cnt = 0;
    end
  end

  // Compare process: bus requests and tx bytes against the model queues.
  always @(negedge mclk) begin
    if (!reset) begin
      if (wb.wbm_cyc_o !== wb.wbm_stb_o) check("cyc_eq_stb", {31'h0, wb.wbm_stb_o}, {31'h0, wb.wbm_cyc_o});
      if (wb.wbm_cyc_o && !prev_cyc) begin
        if (exp_wb.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected actual=cyc adr=%h expected=no_cycle", wb.wbm_adr_o);
        end else begin
          wb_exp_t e;
          e = exp_wb.pop_front();
          check("wb_adr", wb.wbm_adr_o, e.adr);
          check("wb_we", {31'h0, wb.wbm_we_o}, {31'h0, e.we});
          check("wb_sel", {28'h0, wb.wbm_sel_o}, 32'hF);
          if (e.we) check("wb_dat", wb.wbm_dat_o, e.dat);
          last_adr = wb.wbm_adr_o;
          last_dat = wb.wbm_dat_o;
          last_we  = wb.wbm_we_o;
        end
      end
      if (prev_v && !prev_r && !tx_valid) begin
        checks++; errors++;
        $display("FAIL tx_hold actual=tx_valid_dropped expected=held");
      end
      if (tx_valid) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected actual=%h expected=none", tx_data);
        end else begin
          check("tx_data", {24'h0, tx_data}, {24'h0, exp_tx[0]});
          if (tx_ready) begin
            tx_log.push_back(tx_data);
            void'(exp_tx.pop_front());
          end
        end
      end
    end
    prev_cyc = wb.wbm_cyc_o;
    prev_v   = tx_valid;
    prev_r   = tx_ready;
  end

  initial begin
    byte_q_t cmd;
    int      n;
    reset        = 1'b1;
    rx_valid     = 1'b0;
    rx_data      = '0;
    tx_ready     = 1'b1;
    cfg_gap_tmo  = '0;
    wb.wbm_ack_i = 1'b0;
    wb.wbm_err_i = 1'b0;
    wb.wbm_dat_i = '0;
    repeat (3) tick();
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_cyc", {31'h0, wb.wbm_cyc_o}, 32'h0);
    check("rst_stb", {31'h0, wb.wbm_stb_o}, 32'h0);
    check("rst_we", {31'h0, wb.wbm_we_o}, 32'h0);
    check("rst_adr", wb.wbm_adr_o, 32'h0);
    check("rst_dat", wb.wbm_dat_o, 32'h0);
    check("rst_sel", {28'h0, wb.wbm_sel_o}, 32'h0);
    reset = 1'b0;

    // write
    cmd = {8'h57, 8'h30, 8'h02, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_cmd(cmd, M_ACK, 32'h0, 0);
    wait_done("write");
    check("lit_w_adr", last_adr, 32'h3002_0000);
    check("lit_w_dat", last_dat, 32'h1122_3344);
    check("lit_w_we", {31'h0, last_we}, 32'h1);
    check("lit_w_txlen", tx_log.size(), 1);
    check("lit_w_tx", {24'h0, tx_log[0]}, 32'h06);

    // read
    cmd = {8'h52, 8'h30, 8'h00, 8'h00, 8'h00};
    run_cmd(cmd, M_ACK, 32'h4433_2211, 0);
    wait_done("read");
    check("lit_r_adr", last_adr, 32'h3000_0000);
    check("lit_r_txlen", tx_log.size(), 4);
    check("lit_r_tx0", {24'h0, tx_log[0]}, 32'h44);
    check("lit_r_tx3", {24'h0, tx_log[3]}, 32'h11);

    // unknown command byte
    cmd = {8'h41};
    run_cmd(cmd, M_ACK, 32'h0, 0);
    repeat (10) begin
      tick();
      check("inv_busy", {31'h0, busy}, 32'h0);
    end

    // inter-byte gap abort
    cfg_gap_tmo = 16'd100;
    cmd = {8'h57, 8'h30, 8'h02};
    run_cmd(cmd, M_ACK, 32'h0, 0);
    repeat (99) tick();
    check("gap_busy_before", {31'h0, busy}, 32'h1);
    repeat (2) tick();
    check("gap_busy_after", {31'h0, busy}, 32'h0);
    check("gap_no_cyc", {31'h0, wb.wbm_cyc_o}, 32'h0);
    cmd = {8'h52, 8'h00, 8'h00, 8'h00, 8'h10};
    run_cmd(cmd, M_ACK, 32'hDEAD_BEEF, 0);
    wait_done("gap_then_read");
    check("lit_gap_txlen", tx_log.size(), 4);

    // gaps below the limit, slave latency 3
    slv_lat = 3;
    cmd = {8'h52, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
    run_cmd(cmd, M_ACK, 32'hA5C3_0F96, 20);
    wait_done("slow_read");
    slv_lat = 0;
    cfg_gap_tmo = '0;

    // bus error on write, ack+err on read
    cmd = {8'h57, 8'h00, 8'h00, 8'h00, 8'h04, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    run_cmd(cmd, M_ERR, 32'h0, 2);
    wait_done("write_err");
    check("lit_err_tx", {24'h0, tx_log[0]}, 32'h15);
    cmd = {8'h52, 8'h12, 8'h34, 8'h56, 8'h78};
    run_cmd(cmd, M_BOTH, 32'h0102_0304, 0);
    wait_done("read_ackerr");
    check("lit_both_txlen", tx_log.size(), 1);

    // rx byte while the bus cycle is pending is dropped
    slv_lat = 10;
    cmd = {8'h57, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h01};
    run_cmd(cmd, M_ACK, 32'h0, 0);
    tick();
    rx_valid = 1'b1; rx_data = 8'h52;
    tick();
    rx_valid = 1'b0;
    wait_done("rx_in_wbreq");
    slv_lat = 0;

    // tx back-pressure for 50 cycles, with an rx byte during the response
    tx_ready = 1'b0;
    cmd = {8'h52, 8'h30, 8'h00, 8'h00, 8'h00};
    run_cmd(cmd, M_ACK, 32'h4433_2211, 0);
    for (int i = 0; i < 100 && !tx_valid; i++) tick();
    rx_valid = 1'b1; rx_data = 8'h57;
    tick();
    rx_valid = 1'b0;
    repeat (49) tick();
    check("stall_valid", {31'h0, tx_valid}, 32'h1);
    check("stall_data", {24'h0, tx_data}, 32'h44);
    tx_ready = 1'b1;
    wait_done("stall_read");
    check("lit_stall_txlen", tx_log.size(), 4);
    check("lit_stall_tx2", {24'h0, tx_log[2]}, 32'h22);

    // reset while the bus cycle is pending
    cmd = {8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
    run_cmd(cmd, M_SILENT, 32'h0, 0);
    repeat (5) tick();
    check("mid_cyc_up", {31'h0, wb.wbm_cyc_o}, 32'h1);
    reset = 1'b1;
    exp_tx.delete();
    tick();
    check("mid_rst_cyc", {31'h0, wb.wbm_cyc_o}, 32'h0);
    check("mid_rst_stb", {31'h0, wb.wbm_stb_o}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_txv", {31'h0, tx_valid}, 32'h0);
    reset = 1'b0;
    slv_mode = M_ACK;
    tick();

`ifdef UART_CMD_WBTO_EN
    cmd = {8'h57, 8'h00, 8'h00, 8'h01, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88};
    run_cmd(cmd, M_SILENT, 32'h0, 0);
    for (int i = 0; i < 20 && !wb.wbm_cyc_o; i++) tick();
    n = 0;
    while (wb.wbm_cyc_o && n < 1000) begin
      tick();
      n++;
    end
    check("wdog_cycles", n, 255);
    wait_done("wdog");
    check("lit_wdog_tx", {24'h0, tx_log[0]}, 32'h15);
    slv_mode = M_ACK;
`else
    n = 0;
`endif

    repeat (5) tick();
    check("end_exp_tx_empty", exp_tx.size(), 0);
    check("end_exp_wb_empty", exp_wb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 SHALL have parameter WB_TMO, default 255, meaning Wishbone watchdog limit in mclk cycles (used only with UART_CMD_WBTO_EN).
REQ-002 SHALL have port mclk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports rx_valid  in  1 and rx_data  in  8: one-cycle strobe plus received byte from UART RX core.
REQ-005 SHALL have ports tx_valid  out  1, tx_data  out  8, tx_ready  in  1: response byte stream to UART TX core.
REQ-006 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each; wbm_adr_o  out  32; wbm_dat_o  out  32; wbm_sel_o  out  4.
REQ-007 SHALL have ports wbm_dat_i  in  32, wbm_ack_i  in  1, wbm_err_i  in  1.
REQ-008 SHALL have port cfg_gap_tmo  in  16: inter-byte gap limit in cycles; 0 disables.
REQ-009 SHALL have port busy  out  1: high in every state except IDLE.

Function
REQ-010 SHALL implement states IDLE, ADDR, WDATA, WB_REQ, RESP.
REQ-011 IDLE: rx byte 0x57 ('W') -> ADDR with we=1; 0x52 ('R') -> ADDR with we=0; any other byte discarded, stay IDLE, no tx.
REQ-012 ADDR: collect 4 bytes MSB first into wbm_adr_o; after 4th byte -> WDATA if we=1, else WB_REQ.
REQ-013 WDATA: collect 4 bytes MSB first into wbm_dat_o; after 4th -> WB_REQ.
REQ-014 WB_REQ entry: cyc=stb=1 on the cycle after the last byte strobe, sel=4'hF, we per command; held until ack or err.
REQ-015 On ack: cyc/stb deassert next cycle; read captures wbm_dat_i into response register; -> RESP.
REQ-016 On err, or ack and err same cycle: err wins; cyc/stb drop; response = single byte 0x15 (NAK).
REQ-017 RESP write-ok: single byte 0x06 (ACK); read-ok: 4 bytes MSB first of captured data.
REQ-018 tx_valid held with tx_data stable until tx_ready sampled high; byte advances on tx_valid&tx_ready; after last byte -> IDLE next cycle.
REQ-019 rx_valid in WB_REQ or RESP SHALL be ignored (byte dropped, no state change).
REQ-020 Gap counter: 16-bit, cleared on each accepted byte, counts in ADDR/WDATA; reaching cfg_gap_tmo with cfg_gap_tmo!=0 -> IDLE, byte counter cleared, no WB cycle, no tx.
REQ-021 Byte counter 2-bit, wraps 3->0 at field end; no other arithmetic overflow possible.

Reset
REQ-022 With reset high at a clock edge: state=IDLE, cyc/stb/we=0, adr/dat_o=0, sel=0, tx_valid=0, tx_data=0, busy=0, counters=0.
REQ-023 Reset mid-transaction SHALL drop cyc/stb on the next edge without waiting for ack; pending response discarded.

Configuration
REQ-024 Macro UART_CMD_WBTO_EN defined: watchdog counts in WB_REQ; WB_TMO cycles without ack/err -> cyc/stb drop, respond 0x15.
REQ-025 Macro UART_CMD_WBTO_EN undefined: no watchdog logic; WB_REQ waits indefinitely; WB_TMO unused.

Structure
REQ-026 Shared package uart_cmd_pkg SHALL hold state enum, command codes 0x57/0x52, response codes 0x06/0x15.
REQ-027 Single module; no sub-module (byte assembler inlined).

Verification
REQ-028 rx 57 30 02 00 00 11 22 33 44 -> one WB write adr 0x30020000 dat 0x11223344 sel F, tx 06.
REQ-029 rx 52 30 00 00 00, slave returns 0x44332211 with ack -> WB read, tx 44 33 22 11 in order.
REQ-030 rx 41 -> no cyc, no tx, busy stays 0.
REQ-031 cfg_gap_tmo=100, rx 57 30 02 then 101 idle cycles -> IDLE, no cyc; following read command completes normally.
REQ-032 Slave asserts err on write -> tx 15; with UART_CMD_WBTO_EN, WB_TMO=255, slave silent -> cyc drops at 255 cycles, tx 15.
REQ-033 Read response with tx_ready low 50 cycles -> tx_valid high, tx_data stable 0x44 throughout, then 4 bytes delivered.
